// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM-stage load/store unit driving a req/ack data bus
module mem_stage_lsu #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TO_W           = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] load_data_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  logic [TO_W-1:0] to_cnt;
  logic [1:0]      lat_size;
  logic            lat_uns;
  logic [1:0]      lat_lane;

  logic        start, illegal, legal_f3, aligned, go, reject;
  logic [3:0]  wstrb_n;
  logic [31:0] wdata_n;
  logic [31:0] ext_data;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    start   = ex_valid & (mem_read ^ mem_write);
    illegal = ex_valid & mem_read & mem_write;
    // Loads allow 000/001/010/100/101, stores only 000/001/010.
    if (mem_read)
      legal_f3 = (funct3[1:0] != 2'b11) && !(funct3[2] && funct3[1]);
    else
      legal_f3 = !funct3[2] && (funct3[1:0] != 2'b11);
    case (funct3[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~alu_result[0];
      default: aligned = (alu_result[1:0] == 2'b00);
    endcase
    go      = (state == IDLE) & start & legal_f3 & aligned;
    reject  = (state == IDLE) & (illegal | (start & ~(legal_f3 & aligned)));
    stall_o = (state == BUSY) | go;
  end

  always_comb begin
    case (funct3[1:0])
      2'b00: begin
        wstrb_n = 4'b0001 << alu_result[1:0];
        wdata_n = {4{store_data[7:0]}};
      end
      2'b01: begin
        wstrb_n = 4'b0011 << {alu_result[1], 1'b0};
        wdata_n = {2{store_data[15:0]}};
      end
      default: begin
        wstrb_n = 4'b1111;
        wdata_n = store_data;
      end
    endcase
  end

  always_comb begin
    rd_byte = bus_rdata[{lat_lane, 3'b000} +: 8];
    rd_half = bus_rdata[{lat_lane[1], 4'b0000} +: 16];
    case (lat_size)
      2'b00:   ext_data = lat_uns ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      2'b01:   ext_data = lat_uns ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: ext_data = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      to_cnt      <= '0;
      lat_size    <= 2'b00;
      lat_uns     <= 1'b0;
      lat_lane    <= 2'b00;
      done_o      <= 1'b0;
      load_data_o <= 32'h0;
      misalign_o  <= 1'b0;
      bus_err_o   <= 1'b0;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= 32'h0;
      bus_wdata   <= 32'h0;
      bus_wstrb   <= 4'b0000;
    end else begin
      done_o     <= 1'b0;
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
      case (state)
        IDLE: begin
          to_cnt <= '0;
          if (go) begin
            bus_req   <= 1'b1;
            bus_we    <= mem_write;
            bus_addr  <= {alu_result[31:2], 2'b00};
            bus_wstrb <= mem_write ? wstrb_n : 4'b0000;
            bus_wdata <= mem_write ? wdata_n : 32'h0;
            lat_size  <= funct3[1:0];
            lat_uns   <= funct3[2];
            lat_lane  <= alu_result[1:0];
            state     <= BUSY;
          end else if (reject) begin
            misalign_o <= 1'b1;
          end
        end
        BUSY: begin
          to_cnt <= to_cnt + TO_W'(1);
          // An ack in the final allowed cycle still completes the access.
          if (bus_ack) begin
            bus_req     <= 1'b0;
            done_o      <= 1'b1;
            load_data_o <= bus_we ? 32'h0 : ext_data;
            state       <= DONE;
          end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            bus_req     <= 1'b0;
            bus_err_o   <= 1'b1;
            load_data_o <= 32'h0;
            state       <= IDLE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - scoreboard bench for mem_stage_lsu with randomized loads/stores
module tb_mem_stage_lsu;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        ex_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] alu_result = 32'h0, store_data = 32'h0;
  logic        stall_o, done_o, misalign_o, bus_err_o, bus_req, bus_we;
  logic [31:0] load_data_o, bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_rdata = 32'h0;
  logic        bus_ack = 1'b0;

  mem_stage_lsu dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .mem_read(mem_read),
    .mem_write(mem_write), .funct3(funct3), .alu_result(alu_result),
    .store_data(store_data), .stall_o(stall_o), .done_o(done_o),
    .load_data_o(load_data_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  localparam int K_DONE = 0, K_MIS = 1, K_ERR = 2;
  typedef struct {int kind; logic [31:0] data; int cyc;} exp_t;
  exp_t sb[$];

  int passed = 0, total = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        cur_legal = 1'b0, cur_we = 1'b0;
  logic [2:0]  cur_f3 = 3'd0;
  logic [31:0] cur_addr = 32'h0, cur_sd = 32'h0, fixed_rdata = 32'h0;
  int          cur_start = 0, ack_lat = -1;
  logic        use_fixed = 1'b0, spur = 1'b0, spur_all = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    case (f3)
      3'd0, 3'd4: begin
        v = (rd >> (8 * int'(a[1:0]))) & 32'hFF;
        if (f3 == 3'd0 && v > 127) v = v + 32'hFFFFFF00;
      end
      3'd1, 3'd5: begin
        v = (rd >> (16 * int'(a[1]))) & 32'hFFFF;
        if (f3 == 3'd1 && v > 32767) v = v + 32'hFFFF0000;
      end
      default: v = rd;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] a);
    case (f3[1:0])
      2'b00:   return 4'(1 << int'(a[1:0]));
      2'b01:   return 4'(3 << (int'(a[1:0]) & 2));
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
    case (f3[1:0])
      2'b00:   return (sd & 32'hFF) * 32'h01010101;
      2'b01:   return (sd & 32'hFFFF) * 32'h00010001;
      default: return sd;
    endcase
  endfunction

  function automatic bit m_reject(input logic r, input logic w, input logic [2:0] f3, input logic [31:0] a);
    int sz;
    if (r && w) return 1'b1;
    if (r && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b1;
    if (w && f3 > 3'd2) return 1'b1;
    sz = 1 << (int'(f3) % 4);
    return (int'(a[1:0]) % sz) != 0;
  endfunction

  task automatic do_op(input logic r, input logic w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd, input int lat);
    int n;
    logic s;
    @(negedge clk); #1;
    if (r || w) begin
      if (m_reject(r, w, f3, a)) sb.push_back('{K_MIS, 32'h0, cyc + 1});
      else begin
        cur_legal = 1'b1; cur_we = w; cur_f3 = f3; cur_addr = a; cur_sd = sd;
        cur_start = cyc; ack_lat = lat;
        if (lat < 0 || lat >= 16) sb.push_back('{K_ERR, 32'h0, cyc + 17});
      end
    end
    ex_valid = 1'b1; mem_read = r; mem_write = w; funct3 = f3;
    alu_result = a; store_data = sd;
    n = 0;
    forever begin
      #1 s = stall_o;
      @(posedge clk);
      if (!s) break;
      n++;
      if (n > 40) begin
        total++;
        $display("FAIL stall_bound: still stalled after %0d cycles, expected release", n);
        break;
      end
      @(negedge clk); #1;
      if (bus_err_o) ex_valid = 1'b0;
    end
    @(negedge clk); #1;
    ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; cur_legal = 1'b0;
  endtask

  // Bus slave: checks request fields on the first busy cycle and predicts the completion.
  initial begin : responder
    int bc;
    bc = 0;
    forever begin
      @(negedge clk);
      bus_ack = 1'b0;
      if (!rst_n) bc = 0;
      else if (bus_req) begin
        if (bc == 0) begin
          chk("req_for_legal_op", cur_legal, 1);
          chk("bus_addr", bus_addr, cur_addr & 32'hFFFFFFFC);
          chk("bus_we", bus_we, cur_we);
          chk("bus_wstrb", bus_wstrb, cur_we ? m_strb(cur_f3, cur_addr) : 4'h0);
          if (cur_we) chk("bus_wdata", bus_wdata, m_wdata(cur_f3, cur_sd));
        end
        chk("stall_busy", stall_o, 1);
        if (bc == ack_lat) begin
          bus_rdata = use_fixed ? fixed_rdata : $urandom;
          bus_ack = 1'b1;
          sb.push_back('{K_DONE, cur_we ? 32'h0 : m_load(cur_f3, cur_addr, bus_rdata),
                         cur_start + ack_lat + 2});
        end
        bc++;
      end else begin
        bc = 0;
        if (spur_all || (spur && $urandom_range(0, 3) == 0)) begin
          bus_ack = 1'b1;
          bus_rdata = $urandom;
        end
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (done_o || misalign_o || bus_err_o)) begin
        if (sb.size() == 0) begin
          total++;
          $display("FAIL unexpected_event: done=%0b misalign=%0b err=%0b, expected none",
                   done_o, misalign_o, bus_err_o);
        end else begin
          e = sb.pop_front();
          chk("event_kind", {done_o, misalign_o, bus_err_o},
              e.kind == K_DONE ? 3'b100 : (e.kind == K_MIS ? 3'b010 : 3'b001));
          chk("event_cycle", cyc, e.cyc);
          if (e.kind != K_MIS) begin
            chk("load_data", load_data_o, e.data);
            chk("bus_req_dropped", bus_req, 0);
          end
          if (done_o) chk("stall_in_done", stall_o, 0);
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_done", done_o, 0);
    chk("rst_misalign", misalign_o, 0);
    chk("rst_bus_err", bus_err_o, 0);
    chk("rst_load_data", load_data_o, 0);
    chk("rst_wstrb", bus_wstrb, 0);
    chk("rst_stall", stall_o, 0);
    #1 rst_n = 1'b1;

    use_fixed = 1'b1;
    fixed_rdata = 32'hDEADBEEF;
    do_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0);
    chk("lw_vector", load_data_o, 32'hDEADBEEF);
    fixed_rdata = 32'h80FF1234;
    do_op(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 1);
    chk("lb_vector", load_data_o, 32'hFFFFFF80);
    do_op(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 2);
    chk("lbu_vector", load_data_o, 32'h00000080);
    do_op(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000ABCD, 0);
    chk("sh_load_data_zero", load_data_o, 32'h0);
    do_op(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 0);
    do_op(1'b0, 1'b1, 3'b010, 32'h300, 32'h12345678, -1);
    chk("timeout_req_low", bus_req, 0);
    do_op(1'b1, 1'b0, 3'b101, 32'h402, 32'h0, 15);
    do_op(1'b1, 1'b1, 3'b010, 32'h500, 32'h0, 0);
    do_op(1'b1, 1'b0, 3'b011, 32'h0, 32'h0, 0);
    do_op(1'b0, 1'b1, 3'b100, 32'h8, 32'h0, 0);

    @(negedge clk); #1;
    cur_legal = 1'b1; cur_we = 1'b0; cur_f3 = 3'b010; cur_addr = 32'h600;
    cur_start = cyc; ack_lat = -1;
    ex_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; alu_result = 32'h600;
    repeat (3) @(negedge clk);
    chk("req_before_reset", bus_req, 1);
    #1 rst_n = 1'b0;
    #1 chk("req_in_reset", bus_req, 0);
    ex_valid = 1'b0; mem_read = 1'b0; cur_legal = 1'b0;
    @(negedge clk); #1 rst_n = 1'b1; spur_all = 1'b1;
    repeat (4) @(negedge clk);
    spur_all = 1'b0;
    chk("no_done_after_reset", done_o, 0);

    use_fixed = 1'b0;
    spur = 1'b1;
    for (int i = 0; i < 150; i++) begin
      int k, lr, lat;
      logic r, w;
      logic [2:0] f3;
      logic [31:0] a;
      k = $urandom_range(0, 19);
      r = (k < 10);
      w = (k >= 9 && k < 19);
      f3 = 3'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a = a & ~32'(f3[1:0] == 2'b10 ? 3 : (f3[1:0] == 2'b01 ? 1 : 0));
      lr = $urandom_range(0, 9);
      lat = (lr == 0) ? -1 : ((lr == 1) ? 15 : $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      do_op(r, w, f3, a, $urandom, lat);
    end
    spur = 1'b0;
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
